// File: rtl/regfile_stream_port_if.sv
// Command, load/dump stream, core and RAM-side signals of one register-file slice port.
// Latency: none (wires only); backpressure carried by cmd/in/out valid-ready pairs.
interface regfile_stream_port_if #(
    parameter int ADDR_W = 5,
    parameter int WIDTH  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W:0]   cmd_count;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic              done;
    logic              busy;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [WIDTH-1:0]  core_din;
    logic [WIDTH-1:0]  core_dout;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [WIDTH-1:0]  ram_din;
    logic [WIDTH-1:0]  ram_dout;

    modport slave (
        input  cmd_valid, cmd_op, cmd_base, cmd_count,
        input  in_valid, in_data, out_ready,
        input  core_we, core_addr, core_din, ram_dout,
        output cmd_ready, in_ready, out_valid, out_data, done, busy,
        output core_dout, ram_we, ram_addr, ram_din
    );

    modport master (
        output cmd_valid, cmd_op, cmd_base, cmd_count,
        output in_valid, in_data, out_ready,
        output core_we, core_addr, core_din, ram_dout,
        input  cmd_ready, in_ready, out_valid, out_data, done, busy,
        input  core_dout, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/regfile_stream_port.sv
// Streaming load/dump controller owning a 32x16 LUT-RAM port while busy; core passes through when idle.
// Latency: LOAD writes same cycle as handshake, DUMP word one cycle after fetch; stalls hold out_data.
module regfile_stream_port #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 16
) (
    input logic                  clock,
    input logic                  reset,
    regfile_stream_port_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DUMP, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  sent_q, sent_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [CNT_W-1:0]  cnt_sat;
    logic              fill;
    logic              drain;

    assign cnt_sat = (bus.cmd_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : bus.cmd_count;
    // idx counts words fetched into the output register, sent counts words handed downstream.
    assign fill    = (state_q == S_DUMP) && (!out_valid_q || bus.out_ready) && (idx_q < n_q);
    assign drain   = out_valid_q && bus.out_ready;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        n_d           = n_q;
        idx_d         = idx_q;
        sent_d        = sent_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        bus.cmd_ready = 1'b0;
        bus.in_ready  = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = ptr_q;
        bus.ram_din   = bus.in_data;
        case (state_q)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.ram_we    = bus.core_we;
                bus.ram_addr  = bus.core_addr;
                bus.ram_din   = bus.core_din;
                if (bus.cmd_valid) begin
                    ptr_d  = bus.cmd_base;
                    n_d    = cnt_sat;
                    idx_d  = '0;
                    sent_d = '0;
                    if (cnt_sat == '0)   state_d = S_DONE;
                    else if (bus.cmd_op) state_d = S_DUMP;
                    else                 state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                bus.in_ready = 1'b1;
                bus.ram_we   = bus.in_valid;
                if (bus.in_valid) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    idx_d = idx_q + CNT_W'(1);
                    if (idx_q == n_q - CNT_W'(1)) state_d = S_DONE;
                end
            end
            S_DUMP: begin
                if (fill) begin
                    out_data_d  = bus.ram_dout;
                    out_valid_d = 1'b1;
                    ptr_d       = ptr_q + ADDR_W'(1);
                    idx_d       = idx_q + CNT_W'(1);
                end else if (drain) begin
                    out_valid_d = 1'b0;
                end
                if (drain) begin
                    sent_d = sent_q + CNT_W'(1);
                    if (sent_q == n_q - CNT_W'(1)) state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            sent_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            sent_q      <= sent_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.done      = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.core_dout = bus.ram_dout;
endmodule

// File: tb/tb_regfile_stream_port.sv
// Directed bench for regfile_stream_port with a behavioural 32x16 async-read RAM behind it.
// Expected RAM contents are tracked in exp_mem, independent of the RAM model the DUT writes.
module tb_regfile_stream_port;
    logic clock;
    logic reset;
    int   vec_cnt;
    int   err_cnt;
    logic [15:0] mem     [32];
    logic [15:0] exp_mem [32];

    regfile_stream_port_if #(.ADDR_W(5), .WIDTH(16)) bus ();

    regfile_stream_port #(.DEPTH(32), .WIDTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    assign bus.ram_dout = mem[bus.ram_addr];

    task automatic issue_cmd(input logic op, input logic [4:0] base, input logic [5:0] cnt);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_base  = base;
        bus.cmd_count = cnt;
        #1;
        vec_cnt++;
        if (bus.cmd_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL cmd_ready got %b exp 1", bus.cmd_ready);
        end
        @(negedge clock);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_load(input logic [4:0] base, input logic [5:0] cnt, input int n,
                           input logic [15:0] seed, input logic cwe);
        logic [4:0]  ea;
        logic [15:0] d;
        issue_cmd(1'b0, base, cnt);
        for (int i = 0; i < n; i++) begin
            ea = 5'(int'(base) + i);
            d  = seed + 16'(i);
            bus.in_valid  = 1'b1;
            bus.in_data   = d;
            bus.core_we   = cwe;
            bus.core_addr = 5'd25;
            bus.core_din  = 16'h1234;
            #1;
            vec_cnt++;
            if ({bus.in_ready, bus.ram_we, bus.ram_addr, bus.ram_din} !== {1'b1, 1'b1, ea, d}) begin
                err_cnt++;
                $display("FAIL load_word%0d got rdy=%b we=%b addr=%0d din=%h exp rdy=1 we=1 addr=%0d din=%h",
                         i, bus.in_ready, bus.ram_we, bus.ram_addr, bus.ram_din, ea, d);
            end
            exp_mem[ea] = d;
            @(negedge clock);
        end
        bus.in_valid = 1'b0;
        #1;
        vec_cnt++;
        if ({bus.done, bus.busy, bus.ram_we, bus.in_ready} !== 4'b1100) begin
            err_cnt++;
            $display("FAIL load_done got done=%b busy=%b we=%b rdy=%b exp 1 1 0 0",
                     bus.done, bus.busy, bus.ram_we, bus.in_ready);
        end
        bus.core_we = 1'b0;
        @(negedge clock);
        vec_cnt++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            err_cnt++;
            $display("FAIL load_idle got done=%b busy=%b exp 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic do_dump(input logic [4:0] base, input logic [5:0] cnt, input int n, input bit toggle);
        int          got;
        int          cyc;
        int          done_cnt;
        bit          stalled;
        logic [15:0] held;
        logic [15:0] ev;
        got = 0; cyc = 0; done_cnt = 0; stalled = 0; held = '0;
        issue_cmd(1'b1, base, cnt);
        while (got < n && cyc < 200) begin
            bus.out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (stalled) begin
                vec_cnt++;
                if (bus.out_data !== held) begin
                    err_cnt++;
                    $display("FAIL dump_hold got %h exp %h", bus.out_data, held);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                ev = exp_mem[(int'(base) + got) % 32];
                vec_cnt++;
                if (bus.out_data !== ev) begin
                    err_cnt++;
                    $display("FAIL dump_word%0d got %h exp %h", got, bus.out_data, ev);
                end
                got++;
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = bus.out_data;
            if (bus.done) done_cnt++;
            cyc++;
            @(negedge clock);
        end
        bus.out_ready = 1'b0;
        #1;
        vec_cnt++;
        if (got !== n || done_cnt !== 0) begin
            err_cnt++;
            $display("FAIL dump_count got words=%0d early_done=%0d exp words=%0d early_done=0", got, done_cnt, n);
        end
        vec_cnt++;
        if ({bus.done, bus.out_valid, bus.ram_we} !== 3'b100) begin
            err_cnt++;
            $display("FAIL dump_done got done=%b vld=%b we=%b exp 1 0 0", bus.done, bus.out_valid, bus.ram_we);
        end
        @(negedge clock);
        vec_cnt++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            err_cnt++;
            $display("FAIL dump_idle got done=%b busy=%b exp 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        vec_cnt++;
        if ({bus.busy, bus.done, bus.out_valid, bus.out_data, bus.cmd_ready, bus.in_ready} !== {3'b000, 16'h0, 2'b10}) begin
            err_cnt++;
            $display("FAIL reset_state got busy=%b done=%b vld=%b data=%h cmd_rdy=%b in_rdy=%b exp 0 0 0 0000 1 0",
                     bus.busy, bus.done, bus.out_valid, bus.out_data, bus.cmd_ready, bus.in_ready);
        end
        @(negedge clock);
    endtask

    task automatic test_load_dump_basic();
        do_load(5'd0, 6'd4, 4, 16'h0001, 1'b0);
        do_dump(5'd0, 6'd4, 4, 1'b0);
    endtask

    task automatic test_wrap();
        do_load(5'd30, 6'd4, 4, 16'h0A00, 1'b0);
        do_dump(5'd30, 6'd4, 4, 1'b0);
    endtask

    task automatic test_full_stall();
        do_load(5'd5, 6'd40, 32, 16'h0100, 1'b0);
        do_dump(5'd0, 6'd32, 32, 1'b1);
    endtask

    task automatic test_empty_and_saturate();
        do_load(5'd3, 6'd0, 0, 16'h0000, 1'b0);
        do_dump(5'd3, 6'd0, 0, 1'b0);
        do_dump(5'd7, 6'd40, 32, 1'b0);
    endtask

    task automatic test_core_access();
        bus.core_we   = 1'b1;
        bus.core_addr = 5'd7;
        bus.core_din  = 16'hBEEF;
        #1;
        vec_cnt++;
        if ({bus.ram_we, bus.ram_addr, bus.ram_din} !== {1'b1, 5'd7, 16'hBEEF}) begin
            err_cnt++;
            $display("FAIL core_pass got we=%b addr=%0d din=%h exp 1 7 beef", bus.ram_we, bus.ram_addr, bus.ram_din);
        end
        exp_mem[7] = 16'hBEEF;
        @(negedge clock);
        bus.core_we = 1'b0;
        #1;
        vec_cnt++;
        if (bus.core_dout !== 16'hBEEF) begin
            err_cnt++;
            $display("FAIL core_dout got %h exp beef", bus.core_dout);
        end
        @(negedge clock);
        do_load(5'd18, 6'd3, 3, 16'h0500, 1'b1);
        do_dump(5'd24, 6'd3, 3, 1'b0);
        do_dump(5'd6, 6'd2, 2, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        issue_cmd(1'b0, 5'd0, 6'd5);
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'hC000 + 16'(i);
            exp_mem[i]   = 16'hC000 + 16'(i);
            @(negedge clock);
        end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        vec_cnt++;
        if ({bus.busy, bus.done, bus.cmd_ready} !== 3'b001) begin
            err_cnt++;
            $display("FAIL abort_state got busy=%b done=%b cmd_rdy=%b exp 0 0 1", bus.busy, bus.done, bus.cmd_ready);
        end
        @(negedge clock);
        vec_cnt++;
        if (bus.done !== 1'b0) begin
            err_cnt++;
            $display("FAIL abort_no_done got %b exp 0", bus.done);
        end
        do_dump(5'd0, 6'd3, 3, 1'b0);
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            mem[i]     = '0;
            exp_mem[i] = '0;
        end
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_count = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.core_we   = 1'b0;
        bus.core_addr = '0;
        bus.core_din  = '0;
        @(negedge clock);
        test_reset();
        test_load_dump_basic();
        test_wrap();
        test_full_stall();
        test_empty_and_saturate();
        test_core_access();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
